// File: rtl/core_mem_arbiter.sv
// Shares one memory word port between fetch-side line refills and data-side
// refills/writebacks, one critical-word-first burst per grant, data side first.
module core_mem_arbiter #(
  parameter int BURST_LEN      = 4,
  parameter int MAX_D_CONSEC   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ic_req_i,
  input  logic [29:0] ic_addr_i,
  output logic        ic_rvalid_o,
  output logic        ic_done_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [29:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  output logic        dc_wnext_o,
  output logic        dc_rvalid_o,
  output logic        dc_done_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int L  = $clog2(BURST_LEN);
  localparam int SW = $clog2(MAX_D_CONSEC + 1);

  typedef enum logic [1:0] {IDLE, IC_BURST, DC_BURST, GAP} state_t;

  state_t        state_q, state_d;
  logic          owner_ic_q;
  logic [29:0]   addr_q;
  logic [L-1:0]  beat_q;
  logic [7:0]    tmo_q;
  logic [SW-1:0] starve_q;

  logic bursting, timed_out, beat_ack, last_beat, grant_dc, grant_ic;

  assign bursting  = (state_q == IC_BURST) || (state_q == DC_BURST);
  assign timed_out = bursting && (tmo_q == 8'(TIMEOUT_CYCLES));
  assign beat_ack  = bursting && !timed_out && mem_ack_i;
  assign last_beat = (beat_q == L'(BURST_LEN - 1));

  // Data wins unless the fetch side has already waited through MAX_D_CONSEC data grants.
  assign grant_dc = (state_q == IDLE) && dc_req_i &&
                    !(ic_req_i && (starve_q == SW'(MAX_D_CONSEC)));
  assign grant_ic = (state_q == IDLE) && ic_req_i && !grant_dc;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant_dc) state_d = DC_BURST;
                else if (grant_ic) state_d = IC_BURST;
      IC_BURST,
      DC_BURST: if (timed_out || (beat_ack && last_beat)) state_d = GAP;
      GAP:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: address and beat registers are reset too, keeping outputs deterministic straight after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      owner_ic_q <= 1'b0;
      addr_q     <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      starve_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_dc || grant_ic) begin
        owner_ic_q <= grant_ic;
        addr_q     <= grant_dc ? dc_addr_i : ic_addr_i;
        beat_q     <= '0;
        tmo_q      <= '0;
      end else if (beat_ack) begin
        beat_q <= beat_q + 1'b1;
        tmo_q  <= '0;
      end else if (bursting && !timed_out) begin
        tmo_q <= tmo_q + 8'd1;
      end
      if (!ic_req_i || grant_ic) starve_q <= '0;
      else if (grant_dc && (starve_q != SW'(MAX_D_CONSEC))) starve_q <= starve_q + 1'b1;
    end
  end

  // Beat address wraps inside the aligned line (critical word first).
  assign mem_addr_o  = bursting ? {addr_q[29:L], addr_q[L-1:0] + beat_q} : '0;
  assign mem_req_o   = bursting && !timed_out;
  assign mem_we_o    = (state_q == DC_BURST) && dc_we_i;
  assign mem_wdata_o = (state_q == DC_BURST) ? dc_wdata_i : '0;
  assign rdata_o     = bursting ? mem_rdata_i : '0;

  assign ic_rvalid_o = (state_q == IC_BURST) && beat_ack;
  assign dc_rvalid_o = (state_q == DC_BURST) && !dc_we_i && beat_ack;
  assign dc_wnext_o  = (state_q == DC_BURST) && dc_we_i && beat_ack;
  assign err_o       = timed_out;
  assign ic_done_o   = (state_q == GAP) && owner_ic_q;
  assign dc_done_o   = (state_q == GAP) && !owner_ic_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: queued requesters, a transfer-level
// reference model and a configurable memory acknowledge pattern.
module tb_core_mem_arbiter;

  localparam int BL   = 4;
  localparam int MAXC = 4;
  localparam int TO   = 255;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        ic_req_i = 1'b0, dc_req_i = 1'b0, dc_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [29:0] ic_addr_i = '0, dc_addr_i = '0;
  logic [31:0] dc_wdata_i = '0, mem_rdata_i = '0;
  logic        ic_rvalid_o, ic_done_o, dc_wnext_o, dc_rvalid_o, dc_done_o;
  logic        mem_req_o, mem_we_o, err_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic [29:0] mem_addr_o;

  always #5 clk_i = ~clk_i;

  core_mem_arbiter #(.BURST_LEN(BL), .MAX_D_CONSEC(MAXC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_wnext_o(dc_wnext_o), .dc_rvalid_o(dc_rvalid_o), .dc_done_o(dc_done_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {logic [29:0] addr; logic we;} txn_t;
  txn_t ic_q[$], dc_q[$];

  typedef enum {PH_FREE, PH_XFER, PH_DONE} phase_e;
  phase_e      phase = PH_FREE;
  bit          own_ic = 1'b0;
  logic [29:0] a = '0;
  logic        we = 1'b0;
  logic [31:0] wbase = '0;
  int          k = 0, waited = 0, d_run = 0, ack_mode = 1;
  int          n_ic_rv, n_dc_rv, n_wnext, n_ic_done, n_dc_done, n_err;
  string       order;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] beat_addr(input logic [29:0] base, input int beat);
    logic [29:0] line;
    line = base & ~30'(BL - 1);
    return line | 30'((int'(base % BL) + beat) % BL);
  endfunction

  task automatic clear_tally();
    n_ic_rv = 0; n_dc_rv = 0; n_wnext = 0; n_ic_done = 0; n_dc_done = 0; n_err = 0;
    order = "";
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, mem_req_o, 0);
    check({tag, "_mem_we"}, mem_we_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_ic_rvalid"}, ic_rvalid_o, 0);
    check({tag, "_dc_rvalid"}, dc_rvalid_o, 0);
    check({tag, "_dc_wnext"}, dc_wnext_o, 0);
    check({tag, "_ic_done"}, ic_done_o, 0);
    check({tag, "_dc_done"}, dc_done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  task automatic drive();
    ic_req_i   = ic_q.size() != 0;
    ic_addr_i  = ic_req_i ? ic_q[0].addr : '0;
    dc_req_i   = dc_q.size() != 0;
    dc_addr_i  = dc_req_i ? dc_q[0].addr : '0;
    dc_we_i    = dc_req_i ? dc_q[0].we : 1'b0;
    dc_wdata_i = wbase + 32'(k);
    mem_rdata_i = $urandom();
    if (ack_mode < 0)       mem_ack_i = 1'($urandom_range(0, 1));
    else if (ack_mode == 0) mem_ack_i = 1'b0;
    else                    mem_ack_i = (phase == PH_XFER) && (waited % ack_mode == ack_mode - 1);
  endtask

  task automatic observe();
    bit to, ack, g_dc, g_ic;
    n_ic_rv += int'(ic_rvalid_o); n_dc_rv += int'(dc_rvalid_o); n_wnext += int'(dc_wnext_o);
    n_err   += int'(err_o);
    if (ic_done_o) begin n_ic_done++; order = {order, "I"}; end
    if (dc_done_o) begin n_dc_done++; order = {order, "D"}; end
    case (phase)
      PH_FREE: begin
        check_quiet("idle");
        g_dc = dc_req_i && !(ic_req_i && d_run == MAXC);
        g_ic = ic_req_i && !g_dc;
        if (g_ic) d_run = 0;
        else if (g_dc && ic_req_i && d_run < MAXC) d_run++;
        if (g_dc || g_ic) begin
          phase = PH_XFER; own_ic = g_ic; k = 0; waited = 0; wbase = $urandom();
          a  = g_dc ? dc_addr_i : ic_addr_i;
          we = g_dc && dc_we_i;
        end
      end
      PH_XFER: begin
        to  = (waited == TO);
        ack = mem_ack_i && !to;
        check("mem_req", mem_req_o, !to);
        if (!to) check("mem_addr", mem_addr_o, beat_addr(a, k));
        check("mem_we", mem_we_o, !own_ic && we);
        check("mem_wdata", mem_wdata_o, own_ic ? 32'h0 : wbase + 32'(k));
        check("rdata", rdata_o, mem_rdata_i);
        check("ic_rvalid", ic_rvalid_o, own_ic && ack);
        check("dc_rvalid", dc_rvalid_o, !own_ic && !we && ack);
        check("dc_wnext", dc_wnext_o, !own_ic && we && ack);
        check("err", err_o, to);
        check("done_in_burst", {ic_done_o, dc_done_o}, 0);
        if (to) phase = PH_DONE;
        else if (ack) begin
          k++; waited = 0;
          if (k == BL) phase = PH_DONE;
        end else waited++;
      end
      default: begin
        check("ic_done", ic_done_o, own_ic);
        check("dc_done", dc_done_o, !own_ic);
        check("gap_mem_req", mem_req_o, 0);
        check("gap_err", err_o, 0);
        if (own_ic && ic_q.size() != 0) void'(ic_q.pop_front());
        if (!own_ic && dc_q.size() != 0) void'(dc_q.pop_front());
        phase = PH_FREE; k = 0;
      end
    endcase
    if (!ic_req_i) d_run = 0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
    drive();
    @(negedge clk_i);
    observe();
  endtask

  task automatic run(input int budget);
    for (int c = 0; c < budget && (ic_q.size() != 0 || dc_q.size() != 0 || phase != PH_FREE); c++)
      step();
    check("drain", ic_q.size() + dc_q.size() + int'(phase != PH_FREE), 0);
  endtask

  initial begin
    clear_tally();
    // Reset held low, then released away from the clock edge.
    repeat (2) begin @(negedge clk_i); check_quiet("in_reset"); end
    rst_i = 1'b1;
    repeat (2) step();

    // Fetch refill, aligned line, ack every cycle.
    clear_tally(); ack_mode = 1;
    ic_q.push_back('{30'h40, 1'b0});
    run(50);
    check("t1_ic_rvalid_cnt", n_ic_rv, 4);
    check("t1_ic_done_cnt", n_ic_done, 1);

    // Data refill with wrap inside the line.
    clear_tally();
    dc_q.push_back('{30'h102, 1'b0});
    run(50);
    check("t2_dc_rvalid_cnt", n_dc_rv, 4);
    check("t2_dc_done_cnt", n_dc_done, 1);

    // Writeback, ack every third cycle.
    clear_tally(); ack_mode = 3;
    dc_q.push_back('{30'h2A5, 1'b1});
    run(100);
    check("t3_wnext_cnt", n_wnext, 4);
    check("t3_dc_rvalid_cnt", n_dc_rv, 0);

    // Both sides held: four data grants per fetch grant.
    clear_tally(); ack_mode = 1;
    repeat (2) ic_q.push_back('{30'($urandom()), 1'b0});
    repeat (8) dc_q.push_back('{30'($urandom()), 1'b0});
    run(300);
    check("t4_ic_rvalid_cnt", n_ic_rv, 8);
    check("t4_dc_rvalid_cnt", n_dc_rv, 32);
    checks++;
    assert (order == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL t4_grant_order: observed %s expected DDDDIDDDDI", order);
    end

    // Timeout abort, then normal service.
    clear_tally(); ack_mode = 0;
    dc_q.push_back('{30'h300, 1'b0});
    run(400);
    check("t5_err_cnt", n_err, 1);
    check("t5_dc_done_cnt", n_dc_done, 1);
    check("t5_dc_rvalid_cnt", n_dc_rv, 0);
    clear_tally(); ack_mode = 1;
    ic_q.push_back('{30'h1234, 1'b0});
    run(50);
    check("t5_after_ic_rvalid_cnt", n_ic_rv, 4);

    // Random mix with random acknowledges (also outside bursts).
    clear_tally(); ack_mode = -1;
    repeat (6) ic_q.push_back('{30'($urandom()), 1'b0});
    repeat (6) dc_q.push_back('{30'($urandom()), 1'($urandom_range(0, 1))});
    run(3000);
    check("t6_ic_done_cnt", n_ic_done, 6);
    check("t6_dc_done_cnt", n_dc_done, 6);
    check("t6_err_cnt", n_err, 0);

    // Reset asserted during beat 2 of a fetch burst.
    clear_tally(); ack_mode = 1;
    ic_q.push_back('{30'h80, 1'b0});
    for (int c = 0; c < 20 && !(phase == PH_XFER && k == 2); c++) step();
    check("t7_reach_beat2", k, 2);
    @(posedge clk_i); #3;
    mem_ack_i = 1'b1; rst_i = 1'b0;
    #1 check_quiet("t7_async_reset");
    ic_q.delete(); dc_q.delete();
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    phase = PH_FREE; k = 0; waited = 0; d_run = 0;
    @(negedge clk_i); check_quiet("t7_held_reset");
    rst_i = 1'b1;
    repeat (3) step();
    check("t7_no_done", n_ic_done + n_dc_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
